// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter sharing one FIFO write port (WREQ/WD/full)
// among NREQ producers. It grants one producer at a time and forwards its words
// while the FIFO has room. Handover to the next producer costs no bubble.
//
// Optional feature macro: FIFO_ARB_BURST_EN
//   defined   - a grant carries up to BURST_LEN words back-to-back.
//   undefined - the grant is released after every word (word-level round-robin).
//               No burst counter is built.

module fifo_wr_arb #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   wd_in,
  input  logic                 fifo_full,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      ack,
  output logic                 fifo_wreq,
  output logic [DW-1:0]        fifo_wd,
  output logic                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Catch illegal configurations at elaboration time rather than in silicon.
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("fifo_wr_arb: NREQ must be in 2..8");
  end
  if (BURST_LEN < 1 || BURST_LEN > 15) begin : g_bad_burst
    $error("fifo_wr_arb: BURST_LEN must be in 1..15");
  end

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [NREQ-1:0]     gnt_q,   gnt_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;   // index of the last producer served
  logic                busy_q,  busy_d;

`ifdef FIFO_ARB_BURST_EN
  localparam logic [3:0] BURST_W = 4'(BURST_LEN);
  logic [3:0]          burst_cnt_q, burst_cnt_d;
`endif

  // Decoded view of the current grant.
  logic [PW-1:0]       g_idx;     // binary index of the granted producer
  logic                req_g;     // granted producer still requesting
  logic [DW-1:0]       wd_sel;    // granted producer's data word
  logic                limit_hit; // this transfer closes the burst
  logic [NREQ-1:0]     rearb_mask;

  // Round-robin pick: first set bit scanning ptr+1, ptr+2, ... modulo NREQ.
  // Split into the indices above ptr (higher priority) and those at or below
  // it (wrap-around), taking the lowest set bit of each half.
  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [PW-1:0]   ptr);
    logic [NREQ-1:0] oh_hi;
    logic [NREQ-1:0] oh_lo;
    logic            found_hi;
    logic            found_lo;
    oh_hi    = '0;
    oh_lo    = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (r[i]) begin
        if (i > int'(ptr)) begin
          if (!found_hi) begin
            oh_hi[i] = 1'b1;
            found_hi = 1'b1;
          end
        end else if (!found_lo) begin
          oh_lo[i] = 1'b1;
          found_lo = 1'b1;
        end
      end
    end
    return found_hi ? oh_hi : oh_lo;
  endfunction

  // Registered state: FSM state, grant, round-robin pointer, busy and burst count.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values; blocking = here would create order-dependent races.
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      rr_ptr_q    <= PW'(NREQ - 1);
      busy_q      <= 1'b0;
`ifdef FIFO_ARB_BURST_EN
      burst_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_ptr_q    <= rr_ptr_d;
      busy_q      <= busy_d;
`ifdef FIFO_ARB_BURST_EN
      burst_cnt_q <= burst_cnt_d;
`endif
    end
  end

  // Decode the one-hot grant into an index, its request bit and its data.
  always_comb begin
    g_idx  = '0;
    wd_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        g_idx  = PW'(i);
        wd_sel = wd_in[i*DW +: DW];
      end
    end
    req_g = |(req & gnt_q);
  end

  // Next state: arbitration from IDLE, and release / same-cycle handover in GRANT.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_ptr_d   = rr_ptr_q;
    limit_hit  = 1'b0;
    rearb_mask = '0;
`ifdef FIFO_ARB_BURST_EN
    burst_cnt_d = burst_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          gnt_d   = rr_pick(req, rr_ptr_q);
          state_d = S_GRANT;
`ifdef FIFO_ARB_BURST_EN
          burst_cnt_d = '0;
`endif
        end
      end

      S_GRANT: begin
`ifdef FIFO_ARB_BURST_EN
        if (fifo_wreq) begin
          burst_cnt_d = burst_cnt_q + 4'd1;
        end
        limit_hit = fifo_wreq && ((burst_cnt_q + 4'd1) == BURST_W);
`else
        limit_hit = fifo_wreq;
`endif
        // Fullness never releases: with req_g high and no transfer we hold.
        if (!req_g || limit_hit) begin
          rr_ptr_d = g_idx;
          // A producer that withdrew is excluded from the handover; one that
          // merely used up its burst may win again if nobody else is asking.
          rearb_mask = req_g ? req : (req & ~gnt_q);
          gnt_d      = rr_pick(rearb_mask, g_idx);
          state_d    = (|gnt_d) ? S_GRANT : S_IDLE;
`ifdef FIFO_ARB_BURST_EN
          burst_cnt_d = '0;
`endif
        end
      end

      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase

    busy_d = (state_d == S_GRANT);
  end

  // Write-side outputs: combinational from the registered grant and live inputs.
  always_comb begin
    fifo_wreq = (state_q == S_GRANT) && req_g && !fifo_full;
    ack       = fifo_wreq ? gnt_q  : '0;
    fifo_wd   = fifo_wreq ? wd_sel : '0;
  end

  assign gnt  = gnt_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: directed steps from the test plan, then
// a randomized phase, all checked against a cycle-level reference model.
// Honours FIFO_ARB_BURST_EN exactly as the design does.

module tb_fifo_wr_arb;

  localparam int NREQ      = 4;
  localparam int DW        = 8;
  localparam int BURST_LEN = 4;
`ifdef FIFO_ARB_BURST_EN
  localparam int LIMIT = BURST_LEN;
`else
  localparam int LIMIT = 1;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ*DW-1:0]  wd_in;
  logic                fifo_full;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     ack;
  logic                fifo_wreq;
  logic [DW-1:0]       fifo_wd;
  logic                busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the port, who was served last, words this grant.
  int m_owner;
  int m_last;
  int m_words;

  logic       capture = 1'b0;
  logic [7:0] wq[$];

  fifo_wr_arb #(.NREQ(NREQ), .DW(DW), .BURST_LEN(BURST_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .wd_in     (wd_in),
    .fifo_full (fifo_full),
    .gnt       (gnt),
    .ack       (ack),
    .fifo_wreq (fifo_wreq),
    .fifo_wd   (fifo_wd),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit bit_of(input logic [NREQ-1:0] r, input int i);
    return ((int'(r) >> i) & 1) != 0;
  endfunction

  // Next producer after p (exclusive) in circular order that is requesting.
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int off = 1; off <= NREQ; off++) begin
      if (bit_of(r, (p + off) % NREQ)) return (p + off) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = NREQ - 1;
    m_words = 0;
  endtask

  // Advance the model across one clock edge given this cycle's inputs.
  task automatic model_edge(input logic [NREQ-1:0] r, input logic full, input logic rs);
    bit wrote;
    bit withdrew;
    if (rs) begin
      model_reset();
      return;
    end
    if (m_owner < 0) begin
      m_owner = pick(r, m_last);
      m_words = 0;
      return;
    end
    withdrew = !bit_of(r, m_owner);
    wrote    = !withdrew && !full;
    if (wrote) m_words++;
    if (withdrew || (wrote && m_words >= LIMIT)) begin
      m_last  = m_owner;
      m_owner = pick(r, m_last);
      m_words = 0;
    end
  endtask

  // One clock cycle: drive on the falling edge, check 1 time unit later.
  task automatic step(input logic [NREQ-1:0] r, input logic full, input logic rs,
                      input logic [31:0] wd, input string tag);
    logic [NREQ-1:0] e_gnt;
    logic            e_wreq;
    logic [7:0]      e_wd;
    @(negedge clk);
    req       = r;
    fifo_full = full;
    rst       = rs;
    wd_in     = wd;
    #1;
    e_gnt  = (m_owner < 0) ? '0 : NREQ'(1 << m_owner);
    e_wreq = (m_owner >= 0) && bit_of(r, m_owner) && !full;
    e_wd   = e_wreq ? 8'((wd >> (8 * m_owner)) & 32'hFF) : 8'h00;
    check({tag, " gnt"},  32'(gnt),       32'(e_gnt));
    check({tag, " busy"}, 32'(busy),      32'(m_owner >= 0));
    check({tag, " wreq"}, 32'(fifo_wreq), 32'(e_wreq));
    check({tag, " ack"},  32'(ack),       e_wreq ? 32'(e_gnt) : 32'h0);
    check({tag, " wd"},   32'(fifo_wd),   32'(e_wd));
    if (capture && fifo_wreq) wq.push_back(fifo_wd);
    model_edge(r, full, rs);
  endtask

  localparam logic [31:0] WD_SEQ = 32'h1312_1110;

  initial begin
    rst       = 1'b1;
    req       = '0;
    fifo_full = 1'b0;
    wd_in     = '0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset held, then idle with no requests.
    step(4'b0000, 1'b0, 1'b1, 32'h0, "rst");
    for (int i = 0; i < 10; i++) step(4'b0000, 1'b0, 1'b0, 32'h0, "idle");

    // Single requester: grant one cycle later, then a word every cycle.
    for (int i = 0; i < 6; i++) step(4'b0001, 1'b0, 1'b0, 32'h0000_0011, "single");
    step(4'b0000, 1'b0, 1'b0, 32'h0, "single_end");
    step(4'b0000, 1'b0, 1'b0, 32'h0, "single_idle");

    // All four requesting from a fresh reset: check the written word order.
    step(4'b0000, 1'b0, 1'b1, 32'h0, "rr_rst");
    capture = 1'b1;
    for (int i = 0; i < 20; i++) step(4'b1111, 1'b0, 1'b0, WD_SEQ, "rr");
    capture = 1'b0;
    check("rr word count", 32'(wq.size()), 32'd19);
    for (int k = 0; k < wq.size() && k < 19; k++) begin
      check($sformatf("rr word %0d", k), 32'(wq[k]), 32'h10 + 32'((k / LIMIT) % NREQ));
    end

    // Requester 2 stalled by a full FIFO mid-burst, then resumes.
    step(4'b0000, 1'b0, 1'b1, 32'h0, "full_rst");
    for (int i = 0; i < 3; i++) step(4'b0100, 1'b0, 1'b0, WD_SEQ, "full_pre");
    for (int i = 0; i < 5; i++) step(4'b0100, 1'b1, 1'b0, WD_SEQ, "full_hold");
    for (int i = 0; i < 4; i++) step(4'b0100, 1'b0, 1'b0, WD_SEQ, "full_post");

    // Requester 1 withdraws while requester 3 waits.
    step(4'b0000, 1'b0, 1'b1, 32'h0, "drop_rst");
    step(4'b0010, 1'b0, 1'b0, WD_SEQ, "drop_grant");
    step(4'b0010, 1'b0, 1'b0, WD_SEQ, "drop_word");
    step(4'b1000, 1'b0, 1'b0, WD_SEQ, "drop_cycle");
    check("drop handover gnt", 32'(m_owner), 32'd3);
    step(4'b1000, 1'b0, 1'b0, WD_SEQ, "drop_after");

    // Reset mid-burst from requester 0; requester 0 wins first again.
    step(4'b0000, 1'b0, 1'b1, 32'h0, "mid_rst0");
    for (int i = 0; i < 3; i++) step(4'b0001, 1'b0, 1'b0, WD_SEQ, "mid_burst");
    step(4'b0001, 1'b0, 1'b1, WD_SEQ, "mid_rst");
    step(4'b0000, 1'b0, 1'b0, WD_SEQ, "mid_after");
    step(4'b1111, 1'b0, 1'b0, WD_SEQ, "mid_rearb");
    step(4'b1111, 1'b0, 1'b0, WD_SEQ, "mid_first");
    step(4'b0000, 1'b0, 1'b0, WD_SEQ, "mid_stop");

    // Randomized traffic: requests, fullness, data and rare resets.
    for (int i = 0; i < 400; i++) begin
      step(NREQ'($urandom_range(0, 15)), $urandom_range(0, 3) == 0,
           $urandom_range(0, 99) == 0, $urandom, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write-port arbiter that lets up to NREQ producers share the single write port (WREQ/WD/f) of one 8-bit FIFO instance. It sits in the FIFO write clock domain between the producers and the FIFO write side. It grants one producer at a time, forwards that producer's data word by word while the FIFO is not full, and rotates fairly between producers.

## Interface
- NREQ, 4: number of requesters, 2..8.
- DW, 8: data width; must match the FIFO WD width.
- BURST_LEN, 4: maximum consecutive words per grant, 1..15. Used only with FIFO_ARB_BURST_EN.

- clk  in  1: write-side clock, shared with the FIFO write clock.
- rst  in  1: synchronous reset, active-high.
- req  in  NREQ: per-requester write request; bit i belongs to requester i.
- wd_in  in  NREQ*DW: requester data; requester i occupies bits [i*DW +: DW].
- fifo_full  in  1: FIFO full flag (f).
- gnt  out  NREQ: registered one-hot grant; all zero when idle.
- ack  out  NREQ: word accepted this cycle, one-hot, at most one bit set.
- fifo_wreq  out  1: FIFO write request (WREQ).
- fifo_wd  out  DW: FIFO write data (WD).
- busy  out  1: registered; 1 while in GRANT.

## Operation
- State is IDLE or GRANT. Registers are state, gnt, rr_ptr (last served index) and burst_cnt.
- Reset values:
  - state = IDLE, gnt = 0, busy = 0, burst_cnt = 0.
  - rr_ptr = NREQ-1, so requester 0 wins first.
  - Combinational outputs then give ack = 0, fifo_wreq = 0, fifo_wd = 0.
- Arbitration picks the first set req bit scanning rr_ptr+1, rr_ptr+2, … modulo NREQ.
- IDLE: if req != 0, load gnt with the winner, set state = GRANT and burst_cnt = 0. Otherwise stay in IDLE.
- GRANT with granted index g. These outputs are combinational from the registered gnt and the inputs:
  - fifo_wreq = req[g] & ~fifo_full.
  - ack[g] = fifo_wreq.
  - fifo_wd = wd_in[g], or 0 when fifo_wreq = 0.
- A word is transferred in every cycle where ack[g] = 1. On each transfer burst_cnt increments.
- Release condition, evaluated each GRANT cycle:
  - req[g] = 0 (requester withdrew), or
  - a transfer occurs and the burst limit is reached (see Configuration).
- On release:
  - rr_ptr = g.
  - Re-arbitrate in the same cycle using the new pointer and the current req, excluding req[g] when the release was caused by req[g] = 0.
  - If there is a winner, load the new gnt, stay in GRANT and clear burst_cnt. Otherwise go to IDLE with gnt = 0.
- Full: while fifo_full = 1, no transfer occurs, gnt is held, burst_cnt is frozen and no release is caused by fullness. There is no timeout.
- Producer rule: hold req and wd_in stable until ack. Dropping req before ack withdraws the request; the word is not written.
- Reset mid-burst: on the next edge the block returns to reset values and the partial burst is discarded. Words already acked stay in the FIFO.

## Timing
- Request to first possible ack:
  - 1 cycle from IDLE (gnt is registered).
  - 0 extra cycles on a back-to-back handover inside GRANT.
- Steady-state throughput is 1 word per cycle while req[g] = 1 and fifo_full = 0.
- ack and fifo_wreq are same-cycle with respect to fifo_full. The FIFO samples WREQ/WD on the same clk edge.
- Single active requester: released and regranted with no bubble.

## Configuration
- FIFO_ARB_BURST_EN defined: the burst limit is reached when burst_cnt reaches BURST_LEN. A grant therefore carries up to BURST_LEN words back-to-back.
- FIFO_ARB_BURST_EN undefined: the limit is 1 (release after every transfer), giving word-level round-robin. BURST_LEN and burst_cnt are unused and burst_cnt is not instantiated.

## Test plan
- Reset, then req = 4'b0000 for 10 cycles -> gnt = 0, busy = 0, fifo_wreq = 0 throughout.
- req = 4'b0001, wd0 = 0x11, full = 0 -> gnt = 0001 one cycle later, then ack[0] = 1 and fifo_wd = 0x11 on every cycle.
- req = 4'b1111, wd_i = 0x10+i, BURST_EN with BURST_LEN = 4 -> 4×0x10, 4×0x11, 4×0x12, 4×0x13, then 0x10 again. Undefined macro -> 0x10, 0x11, 0x12, 0x13 repeating.
- Requester 2 granted, fifo_full = 1 for 5 cycles mid-burst -> fifo_wreq = 0, gnt = 0100 held, burst_cnt frozen; remaining words resume when full = 0.
- Requester 1 granted, req[1] dropped while req[3] = 1 -> gnt = 1000 on the next cycle, no ack[1] in the drop cycle.
- rst = 1 during a burst from requester 0 -> gnt = 0 and busy = 0 next cycle; after release, requester 0 is granted first again.
